// File: rtl/dp_pkg.sv
// Shared constants and opcode encoding for the execution datapath.
// Imported by exec_datapath and data_mem.
package dp_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_BITS  = 5;
    localparam int MEM_DEPTH  = 32;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOTA  = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_PASSA = 4'h8,
        OP_PASSB = 4'h9,
        OP_NOP   = 4'hF
    } opcode_e;

endpackage

// File: rtl/data_mem.sv
// 32x8 data memory: async reset to index values, synchronous write,
// registered read that returns the pre-write contents on a same-edge write.
module data_mem
    import dp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // NOTE: a memory with a reset value cannot map onto a RAM macro; it
    // becomes a bank of resettable flops, which is fine at 32x8.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            // NOTE: non-blocking assignment makes this read see the old word
            // even when the write above hits the same address.
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/exec_datapath.sv
// Execution datapath: combinational ALU, pipeline registers, data memory
// and the result-select mux returned to the control unit.
module exec_datapath
    import dp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  mem_oob
);

    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_q;

    // NOTE: the default assignment ahead of the case keeps this block
    // latch-free for the unused opcodes 10-15.
    always_comb begin
        alu_b   = sel3 ? offset : operand2;
        alu_out = '0;
        case (opcode)
            OP_ADD:   alu_out = operand1 + alu_b;
            OP_SUB:   alu_out = operand1 - alu_b;
            OP_AND:   alu_out = operand1 & alu_b;
            OP_OR:    alu_out = operand1 | alu_b;
            OP_XOR:   alu_out = operand1 ^ alu_b;
            OP_NOTA:  alu_out = ~operand1;
            OP_SHL:   alu_out = {operand1[DATA_WIDTH-2:0], 1'b0};
            OP_SHR:   alu_out = {1'b0, operand1[DATA_WIDTH-1:1]};
            OP_PASSA: alu_out = operand1;
            OP_PASSB: alu_out = alu_b;
            default:  alu_out = '0;
        endcase
    end

    // The write strobe is delayed one edge so it always pairs with the
    // address that was computed from the same controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mem_oob <= 1'b0;
        end else begin
            alu_q   <= alu_out;
            wr_q    <= w_r & ~sel1;
            wdata_q <= operand2;
            mem_oob <= |alu_out[DATA_WIDTH-1:ADDR_BITS];
        end
    end

    data_mem u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_q),
        .addr  (alu_q[ADDR_BITS-1:0]),
        .wdata (wdata_q),
        .rdata (rd_q)
    );

    assign result2 = sel1 ? alu_q : rd_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Self-checking bench for exec_datapath: opcode vector table, directed
// load/store/reset sequences and randomized traffic against a cycle model.
module tb_exec_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [7:0] offset;
    logic [3:0] opcode;
    logic       sel1;
    logic       sel3;
    logic       w_r;
    logic [7:0] result2;
    logic       mem_oob;

    exec_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .operand1 (operand1),
        .operand2 (operand2),
        .offset   (offset),
        .opcode   (opcode),
        .sel1     (sel1),
        .sel3     (sel3),
        .w_r      (w_r),
        .result2  (result2),
        .mem_oob  (mem_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what each register and memory word must hold.
    int m_mem [32];
    int m_alu, m_wr, m_wdata, m_rd, m_oob;

    typedef struct {
        int op1;
        int op2;
        int off;
        int opc;
        int s3;
        int exp;
        int exp_oob;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return 255 - a;
            6:       return (a * 2) % 256;
            7:       return a / 2;
            8:       return a;
            9:       return b;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = i;
        m_alu = 0; m_wr = 0; m_wdata = 0; m_rd = 0; m_oob = 0;
    endfunction

    function automatic void model_edge();
        int a;
        int b;
        int nxt;
        a   = operand1;
        b   = sel3 ? int'(offset) : int'(operand2);
        nxt = alu_ref(int'(opcode), a, b);
        m_rd = m_mem[m_alu % 32];
        if (m_wr != 0) m_mem[m_alu % 32] = m_wdata;
        m_alu   = nxt;
        m_wr    = (w_r && !sel1) ? 1 : 0;
        m_wdata = operand2;
        m_oob   = (nxt >= 32) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, ".result2"}, int'(result2), sel1 ? m_alu : m_rd);
        check({name, ".mem_oob"}, int'(mem_oob), m_oob);
    endtask

    task automatic drive(input int op1, input int op2, input int off, input int opc,
                         input int s1, input int s3, input int wr);
        operand1 = 8'(op1);
        operand2 = 8'(op2);
        offset   = 8'(off);
        opcode   = 4'(opc);
        sel1     = s1[0];
        sel3     = s3[0];
        w_r      = wr[0];
    endtask

    // Reset asserted away from a clock edge and held across one edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("reset.result2", int'(result2), 0);
        check("reset.mem_oob", int'(mem_oob), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic load_addr(input int a, input string name, input int exp);
        drive(a, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        check(name, int'(result2), exp);
    endtask

    initial begin
        vecs[0]  = '{8'h05, 8'h03, 8'h00, 0,  0, 8'h08, 0};
        vecs[1]  = '{8'h03, 8'h05, 8'h00, 1,  0, 8'hFE, 1};
        vecs[2]  = '{8'hF0, 8'h3C, 8'h00, 2,  0, 8'h30, 1};
        vecs[3]  = '{8'hF0, 8'h0F, 8'h00, 3,  0, 8'hFF, 1};
        vecs[4]  = '{8'hAA, 8'hFF, 8'h00, 4,  0, 8'h55, 1};
        vecs[5]  = '{8'h0F, 8'h99, 8'h00, 5,  0, 8'hF0, 1};
        vecs[6]  = '{8'h81, 8'h00, 8'h00, 6,  0, 8'h02, 0};
        vecs[7]  = '{8'h81, 8'h00, 8'h00, 7,  0, 8'h40, 1};
        vecs[8]  = '{8'h7E, 8'h01, 8'h00, 8,  0, 8'h7E, 1};
        vecs[9]  = '{8'h00, 8'h11, 8'h22, 9,  0, 8'h11, 0};
        vecs[10] = '{8'h00, 8'h11, 8'h22, 9,  1, 8'h22, 1};
        vecs[11] = '{8'hFF, 8'h40, 8'h02, 0,  1, 8'h01, 0};
        vecs[12] = '{8'h12, 8'h34, 8'h56, 10, 1, 8'h00, 0};
        vecs[13] = '{8'hFF, 8'hFF, 8'hFF, 15, 0, 8'h00, 0};

        rst = 1'b1;
        drive(0, 0, 0, 15, 1, 0, 0);
        #2;
        do_reset();

        // Load from address 7 straight after reset.
        load_addr(7, "reset.load7", 7);

        // Opcode table on the ALU-register path.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op1, vecs[i].op2, vecs[i].off, vecs[i].opc, 1, vecs[i].s3, 0);
            tick();
            check($sformatf("vec%0d.result2", i), int'(result2), vecs[i].exp);
            check($sformatf("vec%0d.mem_oob", i), int'(mem_oob), vecs[i].exp_oob);
        end

        // Load through base + offset: mem[6] after two edges.
        drive(2, 0, 4, 0, 0, 1, 0);
        tick();
        tick();
        check("load.base_off", int'(result2), 6);

        // Reset dropped while a store's write strobe is pending.
        drive(1, 8'h5A, 9, 0, 0, 1, 1);
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_store.result2", int'(result2), 0);
        drive(10, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_store.mem10", int'(result2), 10);

        // Store 0xAA to address 10, held three cycles, then read back.
        drive(1, 8'hAA, 9, 0, 0, 1, 1);
        for (int c = 0; c < 3; c++) tick();
        load_addr(10, "store.load10", 8'hAA);
        for (int a = 0; a < 32; a++) begin
            load_addr(a, $sformatf("store.scan%0d", a), (a == 10) ? 8'hAA : a);
        end

        // Address wrap and out-of-range flag.
        drive(8'h21, 0, 0, 0, 0, 1, 0);
        tick();
        check("wrap.mem_oob", int'(mem_oob), 1);
        tick();
        check("wrap.result2", int'(result2), 1);

        // Reset mid-run, then randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int hold;
            drive($urandom_range(255), $urandom_range(255), $urandom_range(255),
                  $urandom_range(15), $urandom_range(1), $urandom_range(1),
                  $urandom_range(1));
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
